// File: rtl/flow_ctrl_pipe.sv
// Credit-based valid/ready pipeline: STAGES non-stalling register stages feeding a
// first-word-fall-through skid FIFO; Ready_o is registered and independent of Ready_i.
module flow_ctrl_pipe #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STAGES     = 4,
    parameter int unsigned SKID_DEPTH = 8
) (
    input  logic                              CLK,
    input  logic                              RESET_n,
    input  logic                              Clear_i,
    input  logic                              Valid_i,
    input  logic [DATA_W-1:0]                 Data_i,
    output logic                              Ready_o,
    output logic                              Valid_o,
    output logic [DATA_W-1:0]                 Data_o,
    input  logic                              Ready_i,
    output logic [$clog2(SKID_DEPTH+1)-1:0]   Count_o
);

    localparam int unsigned AW = $clog2(SKID_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(SKID_DEPTH + 1);

    logic [STAGES-1:0] stg_vld_q, stg_vld_d;
    logic [DATA_W-1:0] stg_dat_q [STAGES];
    logic [DATA_W-1:0] stg_dat_d [STAGES];
    logic [DATA_W-1:0] mem_q [SKID_DEPTH];
    logic [DATA_W-1:0] mem_d [SKID_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     credits_q, credits_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CW-1:0]     count_q, count_d;

    logic              accept;
    logic              pop;
    logic              fifo_wr;
    logic [DATA_W-1:0] head;

    // Next-state: pipeline shift, FIFO pointers, credit accounting, registered outputs.
    always_comb begin
        accept    = Valid_i & ready_q;
        pop       = valid_q & Ready_i;
        fifo_wr   = stg_vld_q[STAGES-1];

        stg_vld_d = '0;
        for (int k = 0; k < STAGES; k++) stg_dat_d[k] = '0;
        for (int i = 0; i < SKID_DEPTH; i++) mem_d[i] = mem_q[i];
        wr_ptr_d  = wr_ptr_q + PW'(fifo_wr);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        credits_d = credits_q;

        stg_vld_d[0] = accept;
        stg_dat_d[0] = accept ? Data_i : '0;
        for (int k = 1; k < STAGES; k++) begin
            stg_vld_d[k] = stg_vld_q[k-1];
            stg_dat_d[k] = stg_dat_q[k-1];
        end

        if (fifo_wr && !Clear_i) mem_d[wr_ptr_q[AW-1:0]] = stg_dat_q[STAGES-1];

        case ({accept, pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase

        // Clear wins over any same-edge accept or pop.
        if (Clear_i) begin
            stg_vld_d = '0;
            for (int k = 0; k < STAGES; k++) stg_dat_d[k] = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            credits_d = CW'(SKID_DEPTH);
        end

        // Head bypass covers the beat being written into a FIFO that becomes its sole entry.
        head    = (fifo_wr && (wr_ptr_q == rd_ptr_d)) ? stg_dat_q[STAGES-1]
                                                      : mem_q[rd_ptr_d[AW-1:0]];
        valid_d = (wr_ptr_d != rd_ptr_d);
        data_d  = valid_d ? head : '0;
        ready_d = (credits_d != '0);
        count_d = CW'(SKID_DEPTH) - credits_d;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            stg_vld_q <= '0;
            for (int k = 0; k < STAGES; k++) stg_dat_q[k] <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            credits_q <= CW'(SKID_DEPTH);
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            data_q    <= '0;
            count_q   <= '0;
        end else begin
            stg_vld_q <= stg_vld_d;
            for (int k = 0; k < STAGES; k++) stg_dat_q[k] <= stg_dat_d[k];
            for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            credits_q <= credits_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            count_q   <= count_d;
        end
    end

    assign Ready_o = ready_q;
    assign Valid_o = valid_q;
    assign Data_o  = data_q;
    assign Count_o = count_q;

endmodule
